// File: rtl/o9_pkg.sv
// Shared widths, fetch-entry layout and status-state encoding for the o9 fetch path.
package o9_pkg;

    localparam int O9_ADDR_W = 16;
    localparam int O9_WORD_W = 32;
    localparam int O9_ENTRY_W = O9_WORD_W + O9_ADDR_W;

    typedef struct packed {
        logic [O9_WORD_W-1:0] word;
        logic [O9_ADDR_W-1:0] pc;
    } o9_fetch_entry_t;

    typedef enum logic {
        O9_STALL = 1'b0,
        O9_FETCH = 1'b1
    } o9_fetch_state_t;

    function automatic logic [O9_ADDR_W-1:0] o9_pc_inc(input logic [O9_ADDR_W-1:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/o9_fetch_queue.sv
// Circular prefetch FIFO: push at tail, pop at head, flush empties it in one edge.
module o9_fetch_queue
    import o9_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [O9_ENTRY_W-1:0]        push_data,
    input  logic                         pop,
    output logic [O9_ENTRY_W-1:0]        head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    o9_fetch_entry_t  slots [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full && !flush;
    assign do_pop    = pop && !empty && !flush;
    assign head_data = slots[head];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= ptr_next(tail);
            end
            if (do_pop) begin
                head <= ptr_next(head);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is never reset; the top masks the head while the queue is empty.
    always_ff @(posedge clock) begin
        if (do_push && !reset) begin
            slots[tail] <= o9_fetch_entry_t'(push_data);
        end
    end

endmodule

// File: rtl/o9_fetch_unit.sv
// Instruction fetch unit: owns fetch_pc, the prefetch handshake and the fetch status.
// Optional O9_FETCH_PERF_EN adds perf_fetch_count / perf_stall_count outputs.
//
// state    | meaning
// ---------+------------------------------------------------------
// O9_FETCH | an enqueue happens at the edge closing this cycle
// O9_STALL | no enqueue this cycle (reset, redirect, busy or full)
module o9_fetch_unit
    import o9_pkg::*;
#(
    parameter int                   DEPTH    = 4,
    parameter logic [O9_ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic [O9_ADDR_W-1:0] mem_address,
    input  logic [O9_WORD_W-1:0] mem_q,
    input  logic                 mem_busy,
    input  logic                 redirect_valid,
    input  logic [O9_ADDR_W-1:0] redirect_pc,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [O9_WORD_W-1:0] inst_word,
    output logic [O9_ADDR_W-1:0] inst_pc
`ifdef O9_FETCH_PERF_EN
    ,
    output logic [31:0]          perf_fetch_count,
    output logic [31:0]          perf_stall_count
`endif
);

    logic [O9_ADDR_W-1:0]       fetch_pc;
    logic                       enq;
    logic                       deq;
    o9_fetch_state_t            state;
    logic [O9_ENTRY_W-1:0]      q_head;
    logic [$clog2(DEPTH+1)-1:0] q_count;
    logic                       q_full;
    o9_fetch_entry_t            head_entry;

    assign mem_address = fetch_pc;

    // Status is decided afresh every cycle; nothing carries over between cycles.
    always_comb begin
        enq   = 1'b0;
        deq   = 1'b0;
        state = O9_STALL;
        if (!reset && !redirect_valid) begin
            enq = !mem_busy && !q_full;
            deq = inst_valid && inst_ready;
        end
        if (enq) begin
            state = O9_FETCH;
        end
    end

    o9_fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (enq),
        .push_data ({mem_q, fetch_pc}),
        .pop       (deq),
        .head_data (q_head),
        .count     (q_count),
        .full      (q_full)
    );

    assign head_entry = o9_fetch_entry_t'(q_head);
    assign inst_valid = !reset && (q_count != '0);
    assign inst_word  = inst_valid ? head_entry.word : '0;
    assign inst_pc    = inst_valid ? head_entry.pc   : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
        end else if (enq) begin
            fetch_pc <= o9_pc_inc(fetch_pc);
        end
    end

`ifdef O9_FETCH_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetch_count <= '0;
            perf_stall_count <= '0;
        end else begin
            if (enq) begin
                perf_fetch_count <= perf_fetch_count + 32'd1;
            end
            if (state == O9_STALL) begin
                perf_stall_count <= perf_stall_count + 32'd1;
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_o9_fetch_unit.sv
// Bench for o9_fetch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_o9_fetch_unit;
    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] mem_address;
    logic [31:0] mem_q;
    logic        mem_busy;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_word;
    logic [15:0] inst_pc;
`ifdef O9_FETCH_PERF_EN
    logic [31:0] perf_fetch_count;
    logic [31:0] perf_stall_count;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;
`endif

    always #5 clock = ~clock;

    function automatic logic [31:0] ram_word(input logic [15:0] a);
        return {a ^ 16'h5A3C, ~a + 16'h1234};
    endfunction

    assign mem_q = ram_word(mem_address);

    o9_fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .mem_address    (mem_address),
        .mem_q          (mem_q),
        .mem_busy       (mem_busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_word      (inst_word),
        .inst_pc        (inst_pc)
`ifdef O9_FETCH_PERF_EN
        ,
        .perf_fetch_count (perf_fetch_count),
        .perf_stall_count (perf_stall_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference: queue of {word, pc} plus the next address to fetch.
    logic [47:0] mq[$];
    logic [15:0] mpc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic b, input logic rv,
                        input logic [15:0] rp, input logic rd);
        logic        exp_valid;
        logic        do_enq;
        logic [47:0] head;
        reset          = r;
        mem_busy       = b;
        redirect_valid = rv;
        redirect_pc    = rp;
        inst_ready     = rd;
        #1;
        exp_valid = !r && (mq.size() != 0);
        head      = exp_valid ? mq[0] : 48'h0;
        chk("valid", {31'b0, inst_valid}, {31'b0, exp_valid});
        chk("word", inst_word, head[47:16]);
        chk("pc", {16'b0, inst_pc}, {16'b0, head[15:0]});
        chk("mem_address", {16'b0, mem_address}, {16'b0, mpc});
`ifdef O9_FETCH_PERF_EN
        chk("perf_fetch", perf_fetch_count, m_fetch);
        chk("perf_stall", perf_stall_count, m_stall);
`endif
        do_enq = 1'b0;
        if (r) begin
            mq.delete();
            mpc = RESET_PC;
`ifdef O9_FETCH_PERF_EN
            m_fetch = 0;
            m_stall = 0;
`endif
        end else if (rv) begin
            mq.delete();
            mpc = rp;
        end else begin
            do_enq = !b && (mq.size() < DEPTH);
            if (exp_valid && rd) void'(mq.pop_front());
            if (do_enq) begin
                mq.push_back({ram_word(mpc), mpc});
                mpc = mpc + 16'd1;
            end
        end
`ifdef O9_FETCH_PERF_EN
        if (!r) begin
            if (do_enq) m_fetch = m_fetch + 1;
            else        m_stall = m_stall + 1;
        end
`endif
        @(negedge clock);
    endtask

    initial begin
        reset          = 1'b1;
        mem_busy       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        inst_ready     = 1'b0;
        repeat (2) @(negedge clock);
        mpc = RESET_PC;
`ifdef O9_FETCH_PERF_EN
        m_fetch = 0;
        m_stall = 0;
`endif

        // Reset release, then A..D stream out back to back.
        step(1, 0, 0, 16'h0, 1);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        step(0, 0, 0, 16'h0, 1);
        chk("rel_valid", {31'b0, inst_valid}, 32'd1);
        chk("rel_pc", {16'b0, inst_pc}, 32'd0);
        chk("rel_word", inst_word, ram_word(16'h0000));
        for (int i = 1; i < 4; i++) begin
            step(0, 0, 0, 16'h0, 1);
            chk("seq_pc", {16'b0, inst_pc}, i);
        end

        // Decoder stalls: queue saturates at DEPTH, head holds.
        step(0, 0, 1, 16'h0000, 0);
        repeat (6) step(0, 0, 0, 16'h0, 0);
        chk("sat_addr", {16'b0, mem_address}, 32'd4);
        chk("sat_pc", {16'b0, inst_pc}, 32'd0);
        chk("sat_word", inst_word, ram_word(16'h0000));
        repeat (5) step(0, 0, 0, 16'h0, 1);

        // Redirect with entries queued.
        step(0, 0, 1, 16'h0100, 1);
        chk("redir_valid", {31'b0, inst_valid}, 32'd0);
        step(0, 0, 0, 16'h0, 1);
        chk("redir_pc", {16'b0, inst_pc}, 32'h0100);
        chk("redir_word", inst_word, ram_word(16'h0100));

        // RAM owned by the data side for three cycles.
        repeat (3) step(0, 1, 0, 16'h0, 1);
        repeat (4) step(0, 0, 0, 16'h0, 1);

        // Address wrap and reset beating a simultaneous redirect.
        step(0, 0, 1, 16'hFFFF, 1);
        step(0, 0, 0, 16'h0, 1);
        chk("wrap_pc0", {16'b0, inst_pc}, 32'hFFFF);
        step(0, 0, 0, 16'h0, 1);
        chk("wrap_pc1", {16'b0, inst_pc}, 32'h0000);
        step(1, 0, 1, 16'h1234, 1);
        chk("rst_redir_addr", {16'b0, mem_address}, {16'b0, RESET_PC});
        chk("rst_redir_valid", {31'b0, inst_valid}, 32'd0);

`ifdef O9_FETCH_PERF_EN
        step(1, 0, 0, 16'h0, 1);
        for (int i = 0; i < 10; i++) step(0, (i == 2 || i == 5 || i == 8), 0, 16'h0, 1);
        chk("perf_fetch7", perf_fetch_count, 32'd7);
        chk("perf_stall3", perf_stall_count, 32'd3);
`endif

        // Random traffic, with redirect targets biased toward the wrap point.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] rp;
            rp = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFD + $urandom_range(0, 4))
                                              : 16'($urandom);
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 19) == 0),
                 rp,
                 ($urandom_range(0, 9) < 6));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/o9_fetch_unit.md
O9_FETCH_UNIT -- requirements
Module: o9_fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, prefetch queue entries, legal range 2..16.
REQ-002 Parameter RESET_PC, default 16'h0000, word address of the first instruction fetched after reset.
REQ-003 clock  in  1  rising-edge system clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 mem_address  out  16  word address driven to the RAM read port; always equals fetch_pc.
REQ-006 mem_q  in  32  RAM read data; combinational from mem_address within the same cycle.
REQ-007 mem_busy  in  1  data side owns the RAM this cycle; fetch SHALL NOT capture mem_q.
REQ-008 redirect_valid  in  1  branch/jump taken; flush and refetch.
REQ-009 redirect_pc  in  16  target word address, sampled when redirect_valid=1.
REQ-010 inst_valid  out  1  queue head holds a valid instruction.
REQ-011 inst_ready  in  1  decoder accepts the head this cycle.
REQ-012 inst_word  out  32  head instruction word.
REQ-013 inst_pc  out  16  word address of the head instruction.

Function
REQ-014 Enqueue occurs at a rising edge iff reset=0, redirect_valid=0, mem_busy=0 and count<DEPTH. Enqueue stores {mem_q, fetch_pc} at the tail and sets fetch_pc to fetch_pc+1.
REQ-015 Dequeue occurs at a rising edge iff inst_valid=1, inst_ready=1 and redirect_valid=0.
REQ-016 Enqueue and dequeue in the same cycle SHALL both occur, leaving count unchanged.
REQ-017 Full (count=DEPTH) SHALL block enqueue even if a dequeue occurs that cycle; there is no bypass.
REQ-018 inst_valid = (count!=0). inst_word and inst_pc are driven from the head entry and SHALL remain stable while inst_valid=1 and inst_ready=0.
REQ-019 Latency: a word enqueued at edge N is visible at the head no earlier than the cycle after edge N. Steady-state throughput is 1 instruction/cycle.
REQ-020 Redirect: at the edge with redirect_valid=1, count<=0 and fetch_pc<=redirect_pc. No enqueue and no dequeue happen that cycle. Redirect overrides all other events.
REQ-021 After a redirect, inst_valid=0 for exactly one cycle (absent mem_busy). The target instruction is then at the head with inst_pc=redirect_pc.
REQ-022 Wrap-around: fetch_pc 16'hFFFF increments to 16'h0000. Queue pointers wrap modulo DEPTH.
REQ-023 Internal status FSM, 2 states. FETCH is the state in a cycle where an enqueue occurs; STALL is every other cycle. Transitions are purely per-cycle, with no hold-over.
REQ-024 mem_busy=1 SHALL neither alter fetch_pc nor discard queued entries.

Reset
REQ-025 While reset=1: fetch_pc=RESET_PC, count=0, head/tail=0, inst_valid=0, inst_word=0, inst_pc=0, FSM=STALL.
REQ-026 Reset asserted mid-operation discards all queued entries at that edge. The first enqueue occurs at the first edge with reset=0.
REQ-027 Queue storage contents need no reset; outputs SHALL be masked to 0 while inst_valid=0.

Configuration
REQ-028 Macro O9_FETCH_PERF_EN, when defined, adds outputs perf_fetch_count (32 bits, increments on each enqueue) and perf_stall_count (32 bits, increments each STALL cycle). Both reset to 0 and wrap at 2^32.
REQ-029 Without O9_FETCH_PERF_EN, the ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package o9_pkg holds O9_ADDR_W=16, O9_WORD_W=32, the fetch-entry struct {word, pc}, and the FSM state enum.
REQ-031 Queue storage and pointers live in sub-module o9_fetch_queue: a circular FIFO with push, pop, flush, full/empty and count. o9_fetch_unit owns fetch_pc, the FSM and the handshake.

Verification
REQ-032 Reset release, RAM[0..3]=A,B,C,D, inst_ready=1 -> inst_valid rises the cycle after release; heads A,B,C,D on consecutive cycles with inst_pc 0,1,2,3.
REQ-033 inst_ready=0 for 6 cycles, DEPTH=4 -> count saturates at 4, fetch_pc=4, head stays A/pc 0; on ready=1, A..D drain and fetch resumes at pc 4.
REQ-034 redirect_valid=1 with redirect_pc=16'h0100 while 3 entries are queued -> next cycle inst_valid=0; the following cycle head pc=16'h0100 with word RAM[0x100].
REQ-035 mem_busy=1 for 3 cycles with ready=1 -> no enqueue, fetch_pc frozen, queue drains; after busy drops, fetch continues at the same pc with no gap or duplicate.
REQ-036 fetch_pc=16'hFFFF, enqueue -> entry pc 16'hFFFF, next entry pc 16'h0000. Redirect asserted simultaneously with reset -> reset values win.
REQ-037 With O9_FETCH_PERF_EN, 10 cycles comprising 7 enqueues and 3 busy cycles -> perf_fetch_count=7, perf_stall_count=3.
